// File: rtl/rep1_if.sv
// Byte-replication bus: the source drives the byte, rep1 returns the replicated word.
interface rep1_if #(
  parameter int IN_W = 8,
  parameter int REP  = 4
);
  logic [IN_W-1:0]     in;
  logic [IN_W*REP-1:0] out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/rep1.sv
// Byte-replication register: out <= {REP{in}} on every rising edge, sync active-high reset.
module rep1 #(
  parameter int IN_W = 8,
  parameter int REP  = 4
) (
  input logic   clk,
  input logic   rst,
  rep1_if.slave bus
);
  localparam int OUT_W = IN_W * REP;

  if (REP < 1 || IN_W < 1) begin : g_param_check
    $error("rep1: IN_W and REP must both be >= 1 (IN_W=%0d REP=%0d)", IN_W, REP);
  end

  logic [OUT_W-1:0] rep;

  for (genvar k = 0; k < REP; k++) begin : g_lane
    assign rep[k*IN_W +: IN_W] = bus.in;
  end

  always_ff @(posedge clk) begin
    if (rst) bus.out <= '0;
    else     bus.out <= rep;
  end
endmodule

// File: tb/tb_rep1.sv
// Bench for rep1: directed cases plus random bytes against an arithmetic splat model.
module tb_rep1;
  logic clk;
  logic rst;
  int unsigned vectors;
  int unsigned miscompares;

  rep1_if #(.IN_W(8), .REP(4)) bus ();

  rep1 #(.IN_W(8), .REP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: replicating a byte into four lanes is multiplication by 0x01010101.
  function automatic logic [31:0] splat(input logic [7:0] b, input logic r);
    return r ? 32'h0 : 32'(b) * 32'h0101_0101;
  endfunction

  // Apply inputs, cross one rising edge, check #1 after it.
  task automatic cycle(input logic [7:0] v, input logic r, input string tag);
    bus.in = v;
    rst    = r;
    @(posedge clk);
    #1;
    check(tag, bus.out, splat(v, r));
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] ext [3];
    logic [7:0] v;
    logic       r;
    vectors     = 0;
    miscompares = 0;
    seq = '{8'h02, 8'h7E, 8'h6B, 8'hA8, 8'hFC};
    ext = '{8'h00, 8'hFF, 8'h80};

    // Reset with a non-zero input present: reset wins.
    cycle(8'h7E, 1'b1, "reset_edge1");
    cycle(8'h7E, 1'b1, "reset_edge2");
    cycle(8'h7E, 1'b0, "reset_release");
    cycle(8'hFF, 1'b1, "reset_priority");

    // Each value held for 20 ns (two edges).
    for (int unsigned i = 0; i < 5; i++) begin
      cycle(seq[i], 1'b0, "seq_first_edge");
      cycle(seq[i], 1'b0, "seq_second_edge");
    end

    // Input changes between edges: no combinational path, only the edge sample counts.
    cycle(8'h5A, 1'b0, "latency_setup");
    bus.in = 8'h11;
    #3;
    check("latency_hold_a", bus.out, 32'h5A5A_5A5A);
    bus.in = 8'h22;
    #3;
    check("latency_hold_b", bus.out, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    check("latency_edge_sample", bus.out, 32'h2222_2222);

    for (int unsigned i = 0; i < 3; i++)
      cycle(ext[i], 1'b0, "extreme");

    // Mid-stream single-cycle reset.
    cycle(8'h6B, 1'b0, "midrst_before");
    cycle(8'h6B, 1'b1, "midrst_pulse");
    cycle(8'h6B, 1'b0, "midrst_resume");

    // Random bytes with occasional reset pulses.
    for (int unsigned i = 0; i < 1000; i++) begin
      v = 8'($urandom);
      r = ($urandom_range(31) == 0);
      cycle(v, r, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
